// File: rtl/multi_rect_renderer_pkg.sv
// Shared types for the multi-rectangle overlay renderer: slot record, mode codes
// and the default geometry/colour widths the slot record is built from.
package rr_pkg;

  localparam int RR_X_W = 11;
  localparam int RR_Y_W = 12;
  localparam int RR_C_W = 8;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  typedef struct packed {
    logic                       en;
    logic                       mode;
    logic signed [RR_X_W-1:0]   x;
    logic signed [RR_Y_W-1:0]   y;
    logic        [RR_X_W-1:0]   w;
    logic        [RR_Y_W-1:0]   h;
    logic        [3*RR_C_W-1:0] rgb;
  } rect_cfg_t;

endpackage

// File: rtl/rect_hit_test.sv
// Combinational hit test of one pixel against one rectangle slot (fill or 1-pixel outline).
module rect_hit_test
  import rr_pkg::*;
(
  input  rect_cfg_t                cfg,
  input  logic signed [RR_X_W-1:0] x,
  input  logic signed [RR_Y_W-1:0] y,
  output logic                     hit
);

  // Two guard bits: left edge plus an unsigned full-range width cannot overflow.
  localparam int XE = RR_X_W + 2;
  localparam int YE = RR_Y_W + 2;
  localparam logic signed [XE-1:0] ONE_X = {{(XE-1){1'b0}}, 1'b1};
  localparam logic signed [YE-1:0] ONE_Y = {{(YE-1){1'b0}}, 1'b1};

  logic signed [XE-1:0] px_s, lx_s, rx_s;
  logic signed [YE-1:0] py_s, ty_s, by_s;
  logic                 inside_s, on_edge_s;

  // Rectangle bounds are half-open: [left, left+w) x [top, top+h)
  always_comb begin
    px_s      = XE'(x);
    lx_s      = XE'($signed(cfg.x));
    rx_s      = lx_s + $signed({2'b00, cfg.w});
    py_s      = YE'(y);
    ty_s      = YE'($signed(cfg.y));
    by_s      = ty_s + $signed({2'b00, cfg.h});
    inside_s  = (px_s >= lx_s) && (px_s < rx_s) && (py_s >= ty_s) && (py_s < by_s);
    on_edge_s = inside_s && ((px_s == lx_s) || (px_s == rx_s - ONE_X) ||
                             (py_s == ty_s) || (py_s == by_s - ONE_Y));
    hit       = cfg.en && ((cfg.mode == MODE_OUTLINE) ? on_edge_s : inside_s);
  end

endmodule

// File: rtl/multi_rect_renderer.sv
// Overlays N_RECTS programmable rectangles on a streamed pixel; 2-cycle pipeline,
// lowest slot index wins, slot colours are captured with the pixel to avoid tearing.
module multi_rect_renderer
  import rr_pkg::*;
#(
  parameter int N_RECTS = 4,
  parameter int X_W     = RR_X_W,
  parameter int Y_W     = RR_Y_W,
  parameter int C_W     = RR_C_W,
  localparam int IDX_W  = (N_RECTS > 1) ? $clog2(N_RECTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic signed [X_W-1:0] x,
  input  logic signed [Y_W-1:0] y,
  input  logic        [C_W-1:0] r,
  input  logic        [C_W-1:0] g,
  input  logic        [C_W-1:0] b,
  output logic                  out_valid,
  output logic signed [X_W-1:0] x_out,
  output logic signed [Y_W-1:0] y_out,
  output logic        [C_W-1:0] r_out,
  output logic        [C_W-1:0] g_out,
  output logic        [C_W-1:0] b_out,
  input  logic                  cfg_we,
  input  logic      [IDX_W-1:0] cfg_idx,
  input  logic                  cfg_en,
  input  logic                  cfg_mode,
  input  logic signed [X_W-1:0] cfg_x,
  input  logic signed [Y_W-1:0] cfg_y,
  input  logic        [X_W-1:0] cfg_w,
  input  logic        [Y_W-1:0] cfg_h,
  input  logic      [3*C_W-1:0] cfg_rgb
);

  rect_cfg_t               slots_r     [N_RECTS];
  rect_cfg_t               cfg_new_s;
  logic [N_RECTS-1:0]      hit_s, hit_r;
  logic                    v1_r;
  logic signed [X_W-1:0]   x1_r;
  logic signed [Y_W-1:0]   y1_r;
  logic [3*C_W-1:0]        rgb1_r;
  logic [3*C_W-1:0]        slot_rgb1_r [N_RECTS];
  logic [3*C_W-1:0]        sel_rgb_s;

  // Pack the configuration port into a slot record
  always_comb begin
    cfg_new_s      = '0;
    cfg_new_s.en   = cfg_en;
    cfg_new_s.mode = cfg_mode;
    cfg_new_s.x    = cfg_x;
    cfg_new_s.y    = cfg_y;
    cfg_new_s.w    = cfg_w;
    cfg_new_s.h    = cfg_h;
    cfg_new_s.rgb  = cfg_rgb;
  end

  // Slot table; an index matching no slot leaves the table untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_RECTS; i++) slots_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_RECTS; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) slots_r[i] <= cfg_new_s;
      end
    end
  end

  for (genvar gi = 0; gi < N_RECTS; gi++) begin : g_hit
    rect_hit_test u_hit (
      .cfg (slots_r[gi]),
      .x   (x),
      .y   (y),
      .hit (hit_s[gi])
    );
  end

  // Stage 1: register hits, pixel and the slot colours seen by this pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      x1_r   <= '0;
      y1_r   <= '0;
      rgb1_r <= '0;
      hit_r  <= '0;
      for (int i = 0; i < N_RECTS; i++) slot_rgb1_r[i] <= '0;
    end else begin
      v1_r   <= in_valid;
      x1_r   <= x;
      y1_r   <= y;
      rgb1_r <= {r, g, b};
      hit_r  <= hit_s;
      for (int i = 0; i < N_RECTS; i++) slot_rgb1_r[i] <= slots_r[i].rgb;
    end
  end

  // Priority select: walk from highest index down so the lowest hit wins
  always_comb begin
    sel_rgb_s = rgb1_r;
    for (int i = N_RECTS - 1; i >= 0; i--) begin
      sel_rgb_s = hit_r[i] ? slot_rgb1_r[i] : sel_rgb_s;
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
    end else begin
      out_valid             <= v1_r;
      x_out                 <= x1_r;
      y_out                 <= y1_r;
      {r_out, g_out, b_out} <= sel_rgb_s;
    end
  end

endmodule
